// File: rtl/vga_scan_driver_if.sv
// rtl/vga_scan_driver_if.sv - map-module and DAC pin bundle for vga_scan_driver
//
// Purpose: groups the scan coordinates, returned map pixel and VGA pins.
// Signals:
//   mapData     map -> driver  RGB332 pixel {R[2:0],G[2:0],B[1:0]}
//   test_mode   map -> driver  colour-bar select (only used with VGA_TESTPATTERN_EN)
//   CurrentX    driver -> map  pixel column (0 in blanking)
//   CurrentY    driver -> map  pixel row (0 in blanking)
//   vga_r/g/b   driver -> DAC  colour, black outside active video
//   hsync/vsync driver -> DAC  active-low syncs
//   frame_start driver -> sink 1-cycle pulse with pixel (0,0) at the pins
//   active_out  driver -> sink high while the pins carry visible pixels
// Modports: master = scan driver, slave = map module / pin sink.
interface vga_scan_driver_if;
  logic [7:0] mapData;
  logic       test_mode;
  logic [9:0] CurrentX;
  logic [8:0] CurrentY;
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [1:0] vga_b;
  logic       hsync;
  logic       vsync;
  logic       frame_start;
  logic       active_out;

  modport master (
    input  mapData, test_mode,
    output CurrentX, CurrentY, vga_r, vga_g, vga_b,
    output hsync, vsync, frame_start, active_out
  );

  modport slave (
    output mapData, test_mode,
    input  CurrentX, CurrentY, vga_r, vga_g, vga_b,
    input  hsync, vsync, frame_start, active_out
  );
endinterface

// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - 640x480@60 raster timing master and RGB332 pixel sink
//
// Purpose: runs the h/v scan counters, hands CurrentX/CurrentY to the map
// module, delays sync/active flags by MAP_LATENCY to meet the returned
// mapData, blanks outside active video and registers the VGA pins.
// Counter-to-pin latency is MAP_LATENCY+1 for colour and sync alike.
// Ports:
//   clk_vga  pixel clock (sole clock)
//   rst      synchronous active-high reset
//   vga      vga_scan_driver_if.master (map coordinates/pixel and DAC pins)
// Optional feature: define VGA_TESTPATTERN_EN to build the 8-bar colour
// test pattern selected by test_mode; without it test_mode is ignored.
module vga_scan_driver #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int MAP_LATENCY = 1
) (
  input  logic              clk_vga,
  input  logic              rst,
  vga_scan_driver_if.master vga
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Flags produced at the counter stage and carried alongside the map latency.
`ifdef VGA_TESTPATTERN_EN
  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       tm;
    logic [2:0] bar;
  } stage_t;
`else
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } stage_t;
`endif

  function automatic stage_t idle_stage();
    stage_t s;
    s    = '0;
    s.hs = 1'b1;
    s.vs = 1'b1;
    return s;
  endfunction

`ifdef VGA_TESTPATTERN_EN
  function automatic logic [2:0] bar_of(input logic [9:0] x);
    logic [2:0] b;
    b = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 10'(i * 80)) b = 3'(i);
    end
    return b;
  endfunction

  function automatic logic [7:0] bar_color(input logic [2:0] b);
    case (b)
      3'd0:    return 8'hFF;
      3'd1:    return 8'hFC;
      3'd2:    return 8'h1F;
      3'd3:    return 8'h1C;
      3'd4:    return 8'hE3;
      3'd5:    return 8'hE0;
      3'd6:    return 8'h03;
      default: return 8'h00;
    endcase
  endfunction
`else
  logic unused_test_mode;
  assign unused_test_mode = vga.test_mode;
`endif

  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0] cur_x_q, cur_x_d;
  logic [8:0] cur_y_q, cur_y_d;
  stage_t     s0, tail;
  stage_t     dly_q [MAP_LATENCY];
  stage_t     dly_d [MAP_LATENCY];
  logic [7:0] pix;
  logic [7:0] rgb_q, rgb_d;
  logic       hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, act_q, act_d;

  // Scan counters; CurrentX/Y are registered from the next counter value so
  // they stay aligned with h_cnt/v_cnt without a combinational output path.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
    cur_x_d = '0;
    cur_y_d = '0;
    if ((h_cnt_d < HA) && (v_cnt_d < VA)) begin
      cur_x_d = h_cnt_d;
      cur_y_d = v_cnt_d[8:0];
    end
  end

  always_comb begin
    s0     = idle_stage();
    s0.act = (h_cnt_q < HA) && (v_cnt_q < VA);
    s0.hs  = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    s0.vs  = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    s0.fs  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
`ifdef VGA_TESTPATTERN_EN
    s0.tm  = vga.test_mode;
    s0.bar = bar_of(cur_x_q);
`endif
    dly_d[0] = s0;
    for (int i = 1; i < MAP_LATENCY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
    tail = dly_q[MAP_LATENCY-1];
    pix  = vga.mapData;
`ifdef VGA_TESTPATTERN_EN
    if (tail.tm) pix = bar_color(tail.bar);
`endif
    rgb_d = tail.act ? pix : 8'h00;
    hs_d  = tail.hs;
    vs_d  = tail.vs;
    fs_d  = tail.fs;
    act_d = tail.act;
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      for (int i = 0; i < MAP_LATENCY; i++) dly_q[i] <= idle_stage();
      rgb_q   <= 8'h00;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      dly_q   <= dly_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      act_q   <= act_d;
    end
  end

  assign vga.CurrentX                      = cur_x_q;
  assign vga.CurrentY                      = cur_y_q;
  assign {vga.vga_r, vga.vga_g, vga.vga_b} = rgb_q;
  assign vga.hsync                         = hs_q;
  assign vga.vsync                         = vs_q;
  assign vga.frame_start                   = fs_q;
  assign vga.active_out                    = act_q;

endmodule
